// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request/grant bundle between the CPU/IOP
// requesters and the shared memory-bus arbiter.
interface memory_arbiter_if;
    logic       cpu_req;
    logic [0:1] iop_req;
    logic       cpu_grant;
    logic [0:1] iop_active;
    logic [0:1] bus_owner;
    logic       timeout_err;

    modport master (
        output cpu_req,
        output iop_req,
        input  cpu_grant,
        input  iop_active,
        input  bus_owner,
        input  timeout_err
    );

    modport slave (
        input  cpu_req,
        input  iop_req,
        output cpu_grant,
        output iop_active,
        output bus_owner,
        output timeout_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: non-preemptive CPU/IOP arbiter for the shared
// memory bus with starvation guard, bus turnaround and hold timeout.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TURN_CYCLES  = 1,
    parameter int TIMEOUT      = 64
) (
    input logic             clock,
    input logic             reset,
    memory_arbiter_if.slave bus
);
    localparam int HW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_IOP0 = 2'd2;
    localparam logic [1:0] OWN_IOP1 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic [SW-1:0] r_starve;
    logic [3:0]    r_turn;
    logic          r_last_iop;
    logic          r_blk_cpu;
    logic [0:1]    r_blk_iop;

    logic          w_cpu_el;
    logic [0:1]    w_iop_el;
    logic          w_starved;
    logic [1:0]    w_pick;
    logic          w_owner_req;

    assign w_cpu_el  = bus.cpu_req & ~r_blk_cpu;
    assign w_iop_el  = bus.iop_req & ~r_blk_iop;
    assign w_starved = w_cpu_el && (r_starve == SW'(STARVE_LIMIT));

    // Pick the IDLE winner: starved CPU, then round-robin IOP, then CPU.
    always_comb begin
        w_pick = OWN_NONE;
        if (w_starved)
            w_pick = OWN_CPU;
        else if (w_iop_el[0] && w_iop_el[1])
            w_pick = r_last_iop ? OWN_IOP0 : OWN_IOP1;
        else if (w_iop_el[0])
            w_pick = OWN_IOP0;
        else if (w_iop_el[1])
            w_pick = OWN_IOP1;
        else if (w_cpu_el)
            w_pick = OWN_CPU;
    end

    // Current owner's request line, used to detect release.
    always_comb begin
        w_owner_req = 1'b0;
        case (bus.bus_owner)
            OWN_CPU:  w_owner_req = bus.cpu_req;
            OWN_IOP0: w_owner_req = bus.iop_req[0];
            OWN_IOP1: w_owner_req = bus.iop_req[1];
            default:  w_owner_req = 1'b0;
        endcase
    end

    // Arbitration FSM with registered grant outputs and bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_hold          <= '0;
            r_starve        <= '0;
            r_turn          <= '0;
            r_last_iop      <= 1'b1;
            r_blk_cpu       <= 1'b0;
            r_blk_iop       <= '0;
            bus.cpu_grant   <= 1'b0;
            bus.iop_active  <= '0;
            bus.bus_owner   <= OWN_NONE;
            bus.timeout_err <= 1'b0;
        end else begin
            r_blk_cpu <= r_blk_cpu & bus.cpu_req;
            r_blk_iop <= r_blk_iop & bus.iop_req;
            unique case (r_state)
                IDLE: begin
                    if (w_pick != OWN_NONE) begin
                        r_state        <= GRANT;
                        r_hold         <= HW'(1);
                        bus.bus_owner  <= w_pick;
                        bus.cpu_grant  <= (w_pick == OWN_CPU);
                        bus.iop_active <= {w_pick == OWN_IOP0,
                                           w_pick == OWN_IOP1};
                        if (w_pick == OWN_CPU) begin
                            r_starve <= '0;
                        end else begin
                            r_last_iop <= (w_pick == OWN_IOP1);
                            if (bus.cpu_req &&
                                r_starve != SW'(STARVE_LIMIT))
                                r_starve <= r_starve + SW'(1);
                        end
                    end
                end
                GRANT: begin
                    if (!w_owner_req || r_hold == HW'(TIMEOUT)) begin
                        r_state        <= TURN;
                        r_turn         <= 4'd1;
                        r_hold         <= '0;
                        bus.cpu_grant  <= 1'b0;
                        bus.iop_active <= '0;
                        bus.bus_owner  <= OWN_NONE;
                        if (w_owner_req) begin
                            bus.timeout_err <= 1'b1;
                            case (bus.bus_owner)
                                OWN_CPU:  r_blk_cpu    <= 1'b1;
                                OWN_IOP0: r_blk_iop[0] <= 1'b1;
                                OWN_IOP1: r_blk_iop[1] <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                TURN: begin
                    if (r_turn == 4'(TURN_CYCLES)) begin
                        r_state <= IDLE;
                        r_turn  <= '0;
                    end else begin
                        r_turn <= r_turn + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
